// File: rtl/time_of_day_counter.sv
// Time-of-day stage: divides clk to a 1 s tick, keeps 24 h hh:mm:ss, pulses count_day at midnight.
// A button-driven set FSM edits hour and minute and emits set_day pulses for the downstream day counter.
module time_of_day_counter #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       count_day,
    output logic       set_day
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_DAY  = 2'd3
    } mode_t;

    mode_t            mode_q, mode_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [5:0]       sec_q, sec_nxt;
    logic [5:0]       min_q, min_nxt;
    logic [4:0]       hour_q, hour_nxt;
    logic             count_day_q, count_day_nxt;
    logic             set_day_q, set_day_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= RUN;
            pre_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            count_day_q <= 1'b0;
            set_day_q   <= 1'b0;
        end else begin
            mode_q      <= mode_nxt;
            pre_q       <= pre_nxt;
            sec_q       <= sec_nxt;
            min_q       <= min_nxt;
            hour_q      <= hour_nxt;
            count_day_q <= count_day_nxt;
            set_day_q   <= set_day_nxt;
        end
    end

    always_comb begin
        mode_nxt      = mode_q;
        pre_nxt       = '0;
        sec_nxt       = sec_q;
        min_nxt       = min_q;
        hour_nxt      = hour_q;
        count_day_nxt = 1'b0;
        set_day_nxt   = 1'b0;

        // mode_btn takes priority over both the tick and inc_btn; prescaler restarts on any mode change
        if (mode_btn) begin
            unique case (mode_q)
                RUN:      mode_nxt = SET_HOUR;
                SET_HOUR: mode_nxt = SET_MIN;
                SET_MIN: begin
                    mode_nxt = SET_DAY;
                    sec_nxt  = '0;
                end
                SET_DAY:  mode_nxt = RUN;
                default:  mode_nxt = RUN;
            endcase
        end else begin
            unique case (mode_q)
                RUN: begin
                    if (pre_q == PRE_MAX) begin
                        if (sec_q == 6'd59) begin
                            sec_nxt = '0;
                            if (min_q == 6'd59) begin
                                min_nxt = '0;
                                if (hour_q == 5'd23) begin
                                    hour_nxt      = '0;
                                    count_day_nxt = 1'b1;
                                end else begin
                                    hour_nxt = hour_q + 5'd1;
                                end
                            end else begin
                                min_nxt = min_q + 6'd1;
                            end
                        end else begin
                            sec_nxt = sec_q + 6'd1;
                        end
                    end else begin
                        pre_nxt = pre_q + 1'b1;
                    end
                end
                SET_HOUR: begin
                    if (inc_btn) begin
                        hour_nxt = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end
                end
                SET_MIN: begin
                    if (inc_btn) begin
                        min_nxt = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    end
                end
                SET_DAY: begin
                    set_day_nxt = inc_btn;
                end
                default: ;
            endcase
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign mode      = mode_q;
    assign count_day = count_day_q;
    assign set_day   = set_day_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed scenarios plus random button traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       count_day;
    logic       set_day;

    time_of_day_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .mode      (mode),
        .count_day (count_day),
        .set_day   (set_day)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time held as seconds since midnight
    int tod, m_mode, m_pre, m_cd, m_sd;
    int cd_seen, sd_seen;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        tod = 0; m_mode = 0; m_pre = 0; m_cd = 0; m_sd = 0;
    endtask

    task automatic model_step(input int mb, input int ib);
        int h, mm;
        m_cd = 0;
        m_sd = 0;
        if (mb != 0) begin
            if (m_mode == 2) tod = tod - (tod % 60);
            m_mode = (m_mode + 1) % 4;
            m_pre  = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_pre == CLK_DIV - 1) begin
                        m_pre = 0;
                        tod   = (tod + 1) % 86400;
                        m_cd  = (tod == 0) ? 1 : 0;
                    end else begin
                        m_pre++;
                    end
                end
                1: if (ib != 0) begin
                    h   = (tod / 3600 + 1) % 24;
                    tod = h * 3600 + tod % 3600;
                end
                2: if (ib != 0) begin
                    mm  = ((tod / 60) % 60 + 1) % 60;
                    tod = (tod / 3600) * 3600 + mm * 60 + tod % 60;
                end
                default: m_sd = ib;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".sec"},  int'(sec),  tod % 60);
        check_eq({tag, ".min"},  int'(min),  (tod / 60) % 60);
        check_eq({tag, ".hour"}, int'(hour), tod / 3600);
        check_eq({tag, ".mode"}, int'(mode), m_mode);
        check_eq({tag, ".count_day"}, int'(count_day), m_cd);
        check_eq({tag, ".set_day"},   int'(set_day),   m_sd);
    endtask

    task automatic cycle(input string tag, input int mb, input int ib);
        mode_btn = (mb != 0);
        inc_btn  = (ib != 0);
        @(posedge clk);
        model_step(mb, ib);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        if (count_day) cd_seen++;
        if (set_day)   sd_seen++;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: free run from reset
        cd_seen = 0;
        repeat (8) cycle("run8", 0, 0);
        check_eq("run8_sec", int'(sec), 2);
        check_eq("run8_cd_count", cd_seen, 0);

        // 2: set 23:59, return to RUN, roll over midnight
        cycle("to_sethour", 1, 0);
        repeat (23) cycle("inc_hour", 0, 1);
        cycle("to_setmin", 1, 0);
        repeat (59) cycle("inc_min", 0, 1);
        cycle("to_setday", 1, 0);
        cycle("to_run", 1, 0);
        check_eq("preset_hour", int'(hour), 23);
        check_eq("preset_min", int'(min), 59);
        check_eq("preset_sec", int'(sec), 0);
        cd_seen = 0;
        repeat (240) cycle("midnight", 0, 0);
        check_eq("midnight_hms", int'({hour, min, sec}), 0);
        check_eq("midnight_cd_count", cd_seen, 1);

        // 3: field wrap in SET modes, no carry, no count_day
        cd_seen = 0;
        cycle("t3_sethour", 1, 0);
        repeat (23) cycle("t3_inc_hour", 0, 1);
        check_eq("t3_hour23", int'(hour), 23);
        cycle("t3_hour_wrap", 0, 1);
        check_eq("t3_hour0", int'(hour), 0);
        cycle("t3_setmin", 1, 0);
        repeat (59) cycle("t3_inc_min", 0, 1);
        check_eq("t3_min59", int'(min), 59);
        cycle("t3_min_wrap", 0, 1);
        check_eq("t3_min0", int'(min), 0);
        check_eq("t3_hour_kept", int'(hour), 0);
        check_eq("t3_cd_count", cd_seen, 0);

        // 4: set_day pulses
        cycle("t4_setday", 1, 0);
        sd_seen = 0;
        repeat (3) begin
            cycle("t4_inc", 0, 1);
            check_eq("t4_sd_high", int'(set_day), 1);
            cycle("t4_gap", 0, 0);
            cycle("t4_gap", 0, 0);
        end
        check_eq("t4_sd_count", sd_seen, 3);
        cycle("t4_to_run", 1, 0);

        // 5: inc ignored in RUN; mode_btn beats inc_btn
        repeat (5) cycle("t5_inc_run", 0, 1);
        cycle("t5_both", 1, 1);
        check_eq("t5_mode", int'(mode), 1);
        check_eq("t5_hour", int'(hour), 0);
        repeat (3) cycle("t5_back", 1, 0);

        // 6: async reset in the middle of an edit
        cycle("t6_sethour", 1, 0);
        cycle("t6_setmin", 1, 0);
        repeat (10) cycle("t6_inc_min", 0, 1);
        check_eq("t6_min10", int'(min), 10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Random button traffic
        for (int i = 0; i < 4000; i++) begin
            cycle("rand", ($urandom_range(0, 29) == 0) ? 1 : 0,
                          ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
